// File: rtl/key_pkg.sv
// Shared definitions for the key emulation / debounce path: FSM states,
// LFSR taps and the key polarity both sides agree on.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_BNC,
    HOLD,
    REL_BNC
  } key_state_t;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic        KEY_PRESSED  = 1'b1;
  localparam logic        KEY_RELEASED = 1'b0;

  // One right-shifting Galois step; the tap mask is applied when bit 0 falls out.
  function automatic logic [15:0] lfsr_step(input logic [15:0] q);
    return q[0] ? ((q >> 1) ^ LFSR_TAPS) : (q >> 1);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR; an all-zero seed would lock up, so it
// is replaced by 16'h0001.
module lfsr16
  import key_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] r_q;
  logic [15:0] w_seed;

  assign w_seed = (seed == 16'h0000) ? 16'h0001 : seed;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= w_seed;
    end else begin
      r_q <= lfsr_step(r_q);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/key_bounce_gen.sv
// Mechanical key emulator: on start, drives a press bounce burst, a stable
// hold and a release bounce burst on key, then pulses done.
module key_bounce_gen
  import key_pkg::*;
#(
  parameter int unsigned BOUNCE_CYCLES = 2000,
  parameter int unsigned HOLD_CYCLES   = 40000,
  parameter int unsigned TOGGLE_MAX    = 255,
  parameter logic [15:0] SEED          = 16'hACE1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic key,
  output logic busy,
  output logic done
);

  localparam int unsigned CNT_MAX = (BOUNCE_CYCLES > HOLD_CYCLES) ? BOUNCE_CYCLES : HOLD_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned GAP_W   = $clog2(TOGGLE_MAX + 2);

  localparam logic [CNT_W-1:0] B_LAST  = CNT_W'(BOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [7:0]       T_MASK  = 8'(TOGGLE_MAX);
  localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);

  key_state_t       r_state;
  logic             r_key;
  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] r_cnt;
  logic [GAP_W-1:0] r_gap;

  logic [15:0]      w_lfsr;
  logic             w_unused_lfsr_hi;
  logic [GAP_W-1:0] w_gap_load;
  logic [GAP_W-1:0] w_gap_next;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_gap_expired;
  logic             w_settle_next;
  logic             w_settle_val;
  logic             w_bnc_key;

  lfsr16 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .seed (SEED),
    .q    (w_lfsr)
  );

  assign w_unused_lfsr_hi = ^w_lfsr[15:8];

  // Gap of 1..TOGGLE_MAX+1 cycles until the next bounce toggle.
  assign w_gap_load    = GAP_W'(w_lfsr[7:0] & T_MASK) + GAP_ONE;
  assign w_gap_expired = (r_gap == GAP_ONE);
  assign w_gap_next    = w_gap_expired ? w_gap_load : (r_gap - GAP_ONE);
  assign w_cnt_inc     = r_cnt + CNT_ONE;

  // The last window cycle always shows the settle level, whatever the gap says.
  assign w_settle_next = (w_cnt_inc == B_LAST);
  assign w_settle_val  = (r_state == PRESS_BNC) ? KEY_PRESSED : KEY_RELEASED;
  assign w_bnc_key     = w_settle_next ? w_settle_val : (w_gap_expired ? ~r_key : r_key);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_key   <= KEY_RELEASED;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
      r_gap   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_key <= KEY_RELEASED;
          if (start) begin
            r_state <= PRESS_BNC;
            r_key   <= KEY_PRESSED;
            r_busy  <= 1'b1;
            r_cnt   <= CNT_ONE;
            r_gap   <= w_gap_load;
          end
        end

        PRESS_BNC, REL_BNC: begin
          if (r_cnt == B_LAST) begin
            if (r_state == PRESS_BNC) begin
              r_state <= HOLD;
              r_key   <= KEY_PRESSED;
              r_cnt   <= CNT_ONE;
            end else begin
              r_state <= IDLE;
              r_key   <= KEY_RELEASED;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_cnt   <= '0;
            end
          end else begin
            r_cnt <= w_cnt_inc;
            r_key <= w_bnc_key;
            r_gap <= w_gap_next;
          end
        end

        HOLD: begin
          r_key <= KEY_PRESSED;
          if (r_cnt == H_LAST) begin
            r_state <= REL_BNC;
            r_key   <= KEY_RELEASED;
            r_cnt   <= CNT_ONE;
            r_gap   <= w_gap_load;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        default: begin
          r_state <= IDLE;
          r_key   <= KEY_RELEASED;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign key  = r_key;
  assign busy = r_busy;
  assign done = r_done;

endmodule
